// File: rtl/glitch_pkg.sv
// glitch_pkg: shared types and constants for the glitch sequencer slice.
//   seq_state_e      - sequencer FSM states
//   Def*W            - default counter / config widths
//   LfsrTaps         - tap mask of the 16-bit Fibonacci jitter LFSR (taps 16,14,13,11)
//   LfsrDefaultSeed  - reset value of the jitter LFSR
package glitch_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StDelay,
    StGlitch,
    StGap,
    StDone
  } seq_state_e;

  localparam int unsigned DefDelayW = 16;
  localparam int unsigned DefWidthW = 8;
  localparam int unsigned DefCountW = 8;

  // Bit positions 15,13,12,10 correspond to polynomial taps 16,14,13,11.
  localparam logic [15:0] LfsrTaps        = 16'hB400;
  localparam logic [15:0] LfsrDefaultSeed = 16'hACE1;

endpackage

// File: rtl/glitch_lfsr.sv
// glitch_lfsr: free-running 16-bit Fibonacci LFSR that supplies delay/gap jitter.
// Only present when GLITCH_SEQ_JITTER_EN is defined; otherwise this file is empty.
// Ports:
//   clk     - clock
//   reset   - asynchronous, active-high; loads Seed
//   lfsr_o  - current LFSR state (advances every clock)
`ifdef GLITCH_SEQ_JITTER_EN
module glitch_lfsr
  import glitch_pkg::*;
#(
  parameter logic [15:0] Seed = LfsrDefaultSeed
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_d, lfsr_q;

  // Shift towards the MSB, feedback is the XOR of the tapped bits.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LfsrTaps)};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= Seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule
`endif

// File: rtl/glitch_sequencer.sv
// glitch_sequencer: after arm + trigger, emits a burst of glitch windows toward the
// glitch injector (delay, window width, gap, window count all programmable).
// Build option: GLITCH_SEQ_JITTER_EN adds cfg_jitter_mask and an LFSR that adds
// (lfsr & mask) to the delay and to every gap, saturating.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   arm                   - pulse, latches cfg_* (only in idle)
//   trigger               - level, starts the sequence while armed
//   abort                 - level, returns to idle from any state, no done pulse
//   cfg_delay/width/gap/count/specific - burst configuration
//   cfg_jitter_mask       - jitter mask (GLITCH_SEQ_JITTER_EN only)
//   enable/enable_specific- registered glitch requests, mutually exclusive
//   busy                  - high outside idle
//   done                  - one-cycle completion pulse
//   glitch_idx            - 0-based index of current/last window
module glitch_sequencer
  import glitch_pkg::*;
#(
  parameter int unsigned DELAY_W = DefDelayW,
  parameter int unsigned WIDTH_W = DefWidthW,
  parameter int unsigned COUNT_W = DefCountW
`ifdef GLITCH_SEQ_JITTER_EN
  ,
  parameter logic [15:0] LFSR_SEED = LfsrDefaultSeed
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arm,
  input  logic               trigger,
  input  logic               abort,
  input  logic [DELAY_W-1:0] cfg_delay,
  input  logic [WIDTH_W-1:0] cfg_width,
  input  logic [DELAY_W-1:0] cfg_gap,
  input  logic [COUNT_W-1:0] cfg_count,
  input  logic               cfg_specific,
`ifdef GLITCH_SEQ_JITTER_EN
  input  logic [DELAY_W-1:0] cfg_jitter_mask,
`endif
  output logic               enable,
  output logic               enable_specific,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] glitch_idx
);

  seq_state_e state_q, state_d;

  // Shared delay/gap down-counter and per-window counter.
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  logic [WIDTH_W-1:0] wcnt_q, wcnt_d;
  logic [COUNT_W-1:0] glitch_idx_q, glitch_idx_d;

  // Configuration latched on arm.
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic [DELAY_W-1:0] gap_q, gap_d;
  logic [WIDTH_W-1:0] width_q, width_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               specific_q, specific_d;

  logic enable_q, enable_d;
  logic enable_specific_q, enable_specific_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic [DELAY_W-1:0] jitter;
  logic [DELAY_W-1:0] delay_eff, gap_eff;
  logic [WIDTH_W-1:0] width_eff;
  logic [COUNT_W-1:0] count_eff;
  logic               last_window;

`ifdef GLITCH_SEQ_JITTER_EN
  logic [DELAY_W-1:0] mask_q, mask_d;
  logic [15:0]        lfsr;

  glitch_lfsr #(
    .Seed(LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .lfsr_o(lfsr)
  );

  assign jitter = DELAY_W'(lfsr) & mask_q;
`else
  assign jitter = '0;
`endif

  // Add in one extra bit and clamp so a long delay plus jitter never wraps short.
  function automatic logic [DELAY_W-1:0] sat_add(input logic [DELAY_W-1:0] a,
                                                 input logic [DELAY_W-1:0] b);
    logic [DELAY_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[DELAY_W] ? '1 : sum[DELAY_W-1:0];
  endfunction

  // Jitter is folded in here; the counters only sample these on DELAY/GAP entry.
  assign delay_eff   = sat_add(delay_q, jitter);
  assign gap_eff     = sat_add(gap_q, jitter);
  assign width_eff   = (width_q == '0) ? WIDTH_W'(1) : width_q;
  assign count_eff   = (count_q == '0) ? COUNT_W'(1) : count_q;
  assign last_window = (({1'b0, glitch_idx_q} + (COUNT_W + 1)'(1)) == {1'b0, count_eff});

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wcnt_d       = wcnt_q;
    glitch_idx_d = glitch_idx_q;
    delay_d      = delay_q;
    gap_d        = gap_q;
    width_d      = width_q;
    count_d      = count_q;
    specific_d   = specific_q;
`ifdef GLITCH_SEQ_JITTER_EN
    mask_d       = mask_q;
`endif

    if (abort) begin
      state_d = StIdle;
      cnt_d   = '0;
      wcnt_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arm) begin
            state_d      = StArmed;
            delay_d      = cfg_delay;
            gap_d        = cfg_gap;
            width_d      = cfg_width;
            count_d      = cfg_count;
            specific_d   = cfg_specific;
            glitch_idx_d = '0;
`ifdef GLITCH_SEQ_JITTER_EN
            mask_d       = cfg_jitter_mask;
`endif
          end
        end
        StArmed: begin
          if (trigger) begin
            if (delay_eff == '0) begin
              state_d = StGlitch;
              wcnt_d  = width_eff;
            end else begin
              state_d = StDelay;
              cnt_d   = delay_eff;
            end
          end
        end
        StDelay: begin
          // A count of N keeps the output low for N cycles before the window.
          if (cnt_q <= DELAY_W'(1)) begin
            state_d = StGlitch;
            cnt_d   = '0;
            wcnt_d  = width_eff;
          end else begin
            cnt_d = cnt_q - DELAY_W'(1);
          end
        end
        StGlitch: begin
          if (wcnt_q <= WIDTH_W'(1)) begin
            if (last_window) begin
              state_d = StDone;
              wcnt_d  = '0;
            end else if (gap_eff == '0) begin
              // Back-to-back window: output stays high, only the index moves.
              wcnt_d       = width_eff;
              glitch_idx_d = glitch_idx_q + COUNT_W'(1);
            end else begin
              state_d = StGap;
              cnt_d   = gap_eff;
              wcnt_d  = '0;
            end
          end else begin
            wcnt_d = wcnt_q - WIDTH_W'(1);
          end
        end
        StGap: begin
          if (cnt_q <= DELAY_W'(1)) begin
            state_d      = StGlitch;
            cnt_d        = '0;
            wcnt_d       = width_eff;
            glitch_idx_d = glitch_idx_q + COUNT_W'(1);
          end else begin
            cnt_d = cnt_q - DELAY_W'(1);
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    // Outputs are registered copies of the next state.
    enable_d          = (state_d == StGlitch) && !specific_q;
    enable_specific_d = (state_d == StGlitch) && specific_q;
    busy_d            = (state_d != StIdle);
    done_d            = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= StIdle;
      cnt_q             <= '0;
      wcnt_q            <= '0;
      glitch_idx_q      <= '0;
      delay_q           <= '0;
      gap_q             <= '0;
      width_q           <= '0;
      count_q           <= '0;
      specific_q        <= 1'b0;
      enable_q          <= 1'b0;
      enable_specific_q <= 1'b0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      wcnt_q            <= wcnt_d;
      glitch_idx_q      <= glitch_idx_d;
      delay_q           <= delay_d;
      gap_q             <= gap_d;
      width_q           <= width_d;
      count_q           <= count_d;
      specific_q        <= specific_d;
      enable_q          <= enable_d;
      enable_specific_q <= enable_specific_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
    end
  end

`ifdef GLITCH_SEQ_JITTER_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end
`endif

  assign enable          = enable_q;
  assign enable_specific = enable_specific_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign glitch_idx      = glitch_idx_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Self-checking bench for glitch_sequencer. Expected traces are built from the burst
// rules (window start = delay, windows of max(width,1), gaps, max(count,1) windows).
module tb_glitch_sequencer;

  localparam int MAXC = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        arm = 1'b0;
  logic        trigger = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] cfg_delay = '0;
  logic [7:0]  cfg_width = '0;
  logic [15:0] cfg_gap = '0;
  logic [7:0]  cfg_count = '0;
  logic        cfg_specific = 1'b0;
`ifdef GLITCH_SEQ_JITTER_EN
  logic [15:0] cfg_jitter_mask = '0;
`endif
  logic        enable, enable_specific, busy, done;
  logic [7:0]  glitch_idx;

  int          errors = 0;
  int          checks = 0;
  int unsigned edge_cnt;

  // Expected trace, indexed by edges after the trigger-sampling edge T.
  logic        exp_on   [MAXC];
  logic        exp_busy [MAXC];
  logic        exp_done [MAXC];
  logic [7:0]  exp_idx  [MAXC];
  logic        exp_spec;
  logic [11:0] obs      [MAXC];

  glitch_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .arm            (arm),
    .trigger        (trigger),
    .abort          (abort),
    .cfg_delay      (cfg_delay),
    .cfg_width      (cfg_width),
    .cfg_gap        (cfg_gap),
    .cfg_count      (cfg_count),
    .cfg_specific   (cfg_specific),
`ifdef GLITCH_SEQ_JITTER_EN
    .cfg_jitter_mask(cfg_jitter_mask),
`endif
    .enable         (enable),
    .enable_specific(enable_specific),
    .busy           (busy),
    .done           (done),
    .glitch_idx     (glitch_idx)
  );

  always #5 clk = ~clk;

  // Number of clock edges seen since reset released.
  always @(posedge clk or posedge reset) begin
    if (reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  // LFSR state after n advances from the seed.
  function automatic logic [15:0] lfsr_adv(input int unsigned n);
    logic [15:0] v;
    v = 16'hACE1;
    for (int i = 0; i < int'(n); i++) v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    return v;
  endfunction

  function automatic int unsigned sat16(input int unsigned a, input int unsigned b);
    int unsigned s;
    s = a + b;
    return (s > 65535) ? 65535 : s;
  endfunction

  function automatic logic [11:0] exp_vec(input int k);
    return {exp_on[k] & ~exp_spec, exp_on[k] & exp_spec, exp_busy[k], exp_done[k], exp_idx[k]};
  endfunction

  // steps_t = LFSR advances that precede edge T.
  task automatic build_model(input int unsigned dly, input int unsigned wid,
                             input int unsigned gp, input int unsigned cnt, input bit spec,
                             input logic [15:0] msk, input int unsigned steps_t,
                             output int len);
    int unsigned w, n, pos, jit;
    int          starts[MAXC];
    w = (wid == 0) ? 1 : wid;
    n = (cnt == 0) ? 1 : cnt;
    exp_spec = spec;
    for (int k = 0; k < MAXC; k++) begin
      exp_on[k] = 1'b0; exp_busy[k] = 1'b0; exp_done[k] = 1'b0; exp_idx[k] = '0;
    end
    jit = (msk != 0) ? int'(lfsr_adv(steps_t) & msk) : 0;
    pos = sat16(dly, jit);
    for (int i = 0; i < int'(n); i++) begin
      starts[i] = int'(pos);
      for (int j = 0; j < int'(w); j++) if (pos + j < MAXC) exp_on[pos + j] = 1'b1;
      pos = pos + w;
      if (i < int'(n) - 1) begin
        jit = (msk != 0) ? int'(lfsr_adv(steps_t + pos) & msk) : 0;
        pos = pos + sat16(gp, jit);
      end
    end
    if (pos < MAXC) exp_done[pos] = 1'b1;
    for (int k = 0; k < MAXC; k++) begin
      exp_busy[k] = (k <= int'(pos));
      for (int i = 0; i < int'(n); i++) if (starts[i] <= k) exp_idx[k] = 8'(i);
    end
    len = int'(pos) + 4;
  endtask

  // Arms (with trigger also high, which must be ignored), scrambles cfg after the arm
  // edge, waits pre cycles, then triggers. Returns at the negedge after edge T.
  task automatic start_seq(input int unsigned dly, input int unsigned wid, input int unsigned gp,
                           input int unsigned cnt, input bit spec, input logic [15:0] msk,
                           input int unsigned pre, output int unsigned steps_t);
    @(negedge clk);
    cfg_delay = 16'(dly); cfg_width = 8'(wid); cfg_gap = 16'(gp); cfg_count = 8'(cnt);
    cfg_specific = spec;
`ifdef GLITCH_SEQ_JITTER_EN
    cfg_jitter_mask = msk;
`endif
    arm = 1'b1; trigger = 1'b1;
    @(negedge clk);
    arm = 1'b0; trigger = 1'b0;
    cfg_delay = 16'($urandom); cfg_width = 8'($urandom); cfg_gap = 16'($urandom);
    cfg_count = 8'($urandom); cfg_specific = 1'($urandom);
`ifdef GLITCH_SEQ_JITTER_EN
    cfg_jitter_mask = 16'($urandom);
`endif
    repeat (pre) @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    steps_t = edge_cnt - 1;
  endtask

  task automatic capture(input int len);
    for (int k = 0; k < len; k++) begin
      obs[k] = {enable, enable_specific, busy, done, glitch_idx};
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({enable, enable_specific, busy, done, glitch_idx} !== 12'h000) begin
      errors++;
      $display("FAIL reset_hold: got %b expected %b", {enable, enable_specific, busy, done, glitch_idx}, 12'h000);
    end
    reset = 1'b0;
    trigger = 1'b1;
    repeat (3) @(negedge clk);
    trigger = 1'b0;
    checks++;
    if ({enable, enable_specific, busy, done, glitch_idx} !== 12'h000) begin
      errors++;
      $display("FAIL reset_idle: got %b expected %b", {enable, enable_specific, busy, done, glitch_idx}, 12'h000);
    end
  endtask

  task automatic test_basic;
    int unsigned st; int len;
    start_seq(5, 3, 0, 1, 1'b0, 16'h0, 2, st);
    build_model(5, 3, 0, 1, 1'b0, 16'h0, st, len);
    capture(len);
    for (int k = 0; k < len; k++) begin
      checks++;
      if (obs[k] !== exp_vec(k)) begin
        errors++;
        $display("FAIL basic T+%0d: got en,es,busy,done,idx=%b expected %b", k + 1, obs[k], exp_vec(k));
      end
    end
  endtask

  task automatic test_burst;
    int unsigned st; int len, dones;
    start_seq(0, 2, 4, 3, 1'b1, 16'h0, 0, st);
    build_model(0, 2, 4, 3, 1'b1, 16'h0, st, len);
    capture(len);
    dones = 0;
    for (int k = 0; k < len; k++) begin
      dones += int'(obs[k][8]);
      checks++;
      if (obs[k] !== exp_vec(k)) begin
        errors++;
        $display("FAIL burst T+%0d: got en,es,busy,done,idx=%b expected %b", k + 1, obs[k], exp_vec(k));
      end
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL burst_done_count: got %0d expected 1", dones);
    end
  endtask

  task automatic test_zero_edges;
    int unsigned st; int len;
    start_seq(3, 0, 0, 0, 1'b0, 16'h0, 1, st);
    build_model(3, 0, 0, 0, 1'b0, 16'h0, st, len);
    capture(len);
    for (int k = 0; k < len; k++) begin
      checks++;
      if (obs[k] !== exp_vec(k)) begin
        errors++;
        $display("FAIL zero_single T+%0d: got %b expected %b", k + 1, obs[k], exp_vec(k));
      end
    end
    start_seq(1, 1, 0, 4, 1'b0, 16'h0, 0, st);
    build_model(1, 1, 0, 4, 1'b0, 16'h0, st, len);
    capture(len);
    for (int k = 0; k < len; k++) begin
      checks++;
      if (obs[k] !== exp_vec(k)) begin
        errors++;
        $display("FAIL zero_b2b T+%0d: got %b expected %b", k + 1, obs[k], exp_vec(k));
      end
    end
    checks++;
    if (glitch_idx !== 8'd3) begin
      errors++;
      $display("FAIL zero_b2b_final_idx: got %0d expected 3", glitch_idx);
    end
  endtask

  task automatic test_random;
    int unsigned st, d, w, g, c, pre; bit s; int len;
    for (int it = 0; it < 8; it++) begin
      d = $urandom_range(0, 6); w = $urandom_range(0, 4); g = $urandom_range(0, 4);
      c = $urandom_range(0, 4); s = 1'($urandom); pre = $urandom_range(0, 3);
      start_seq(d, w, g, c, s, 16'h0, pre, st);
      build_model(d, w, g, c, s, 16'h0, st, len);
      capture(len);
      for (int k = 0; k < len; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          errors++;
          $display("FAIL random it%0d d%0d w%0d g%0d c%0d s%0d T+%0d: got %b expected %b",
                   it, d, w, g, c, s, k + 1, obs[k], exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_abort;
    int unsigned st; int dones;
    start_seq(1, 2, 5, 3, 1'b0, 16'h0, 1, st);
    repeat (3) @(negedge clk);  // now inside the first gap
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({enable, enable_specific, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_outputs: got en,es,busy,done=%b expected 0000", {enable, enable_specific, busy, done});
    end
    cfg_delay = 16'd0; cfg_width = 8'd1; cfg_gap = 16'd0; cfg_count = 8'd1; cfg_specific = 1'b0;
`ifdef GLITCH_SEQ_JITTER_EN
    cfg_jitter_mask = 16'h0;
`endif
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    checks++;
    if ({enable, busy, done} !== 3'b010) begin
      errors++;
      $display("FAIL abort_rearm: got en,busy,done=%b expected 010", {enable, busy, done});
    end
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    dones = 0;
    for (int k = 0; k < 50; k++) begin
      dones += int'(done);
      @(negedge clk);
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL abort_followup_done: got %0d pulses expected 1", dones);
    end
  endtask

  task automatic test_async_reset;
    int unsigned st;
    start_seq(2, 6, 0, 1, 1'b0, 16'h0, 0, st);
    repeat (2) @(negedge clk);
    checks++;
    if (enable !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: got enable=%b expected 1", enable);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({enable, enable_specific, busy, done, glitch_idx} !== 12'h000) begin
      errors++;
      $display("FAIL areset_drop: got %b expected %b", {enable, enable_specific, busy, done, glitch_idx}, 12'h000);
    end
    @(negedge clk);
    reset = 1'b0;
    trigger = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if ({enable, enable_specific, busy} !== 3'b000) begin
        errors++;
        $display("FAIL areset_noarm cycle%0d: got en,es,busy=%b expected 000", k, {enable, enable_specific, busy});
      end
    end
    trigger = 1'b0;
  endtask

`ifdef GLITCH_SEQ_JITTER_EN
  task automatic test_jitter;
    int unsigned st; int len, first;
    start_seq(5, 3, 0, 1, 1'b0, 16'h0, 2, st);
    build_model(5, 3, 0, 1, 1'b0, 16'h0, st, len);
    capture(len);
    for (int k = 0; k < len; k++) begin
      checks++;
      if (obs[k] !== exp_vec(k)) begin
        errors++;
        $display("FAIL jitter_mask0 T+%0d: got %b expected %b", k + 1, obs[k], exp_vec(k));
      end
    end
    start_seq(5, 3, 0, 1, 1'b0, 16'h000F, 1, st);
    build_model(5, 3, 0, 1, 1'b0, 16'h000F, st, len);
    capture(len);
    first = -1;
    for (int k = 0; k < len; k++) begin
      if (first < 0 && obs[k][11]) first = k;
      checks++;
      if (obs[k] !== exp_vec(k)) begin
        errors++;
        $display("FAIL jitter_maskF T+%0d: got %b expected %b", k + 1, obs[k], exp_vec(k));
      end
    end
    checks++;
    if (first < 5 || first > 20) begin
      errors++;
      $display("FAIL jitter_range: got first window delay %0d expected within 5..20", first);
    end
    start_seq(3, 2, 2, 3, 1'b1, 16'h0007, 0, st);
    build_model(3, 2, 2, 3, 1'b1, 16'h0007, st, len);
    capture(len);
    for (int k = 0; k < len; k++) begin
      checks++;
      if (obs[k] !== exp_vec(k)) begin
        errors++;
        $display("FAIL jitter_gap T+%0d: got %b expected %b", k + 1, obs[k], exp_vec(k));
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_burst();
    test_zero_edges();
    test_random();
    test_abort();
    test_async_reset();
`ifdef GLITCH_SEQ_JITTER_EN
    test_jitter();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
